// File: rtl/imuldiv_int_muldiv_iterative_param_pkg.sv
// Shared definitions for the iterative multiply/divide unit: function codes,
// FSM state encoding and request-message field layout helpers.
// Pure declarations; no latency and no backpressure of its own.
package imuldiv_int_muldiv_iterative_param_pkg;

  // Function select encodings carried in the request message
  localparam logic [2:0] FN_MUL  = 3'd0;  // signed multiply
  localparam logic [2:0] FN_DIV  = 3'd1;  // signed divide / remainder
  localparam logic [2:0] FN_MULU = 3'd2;  // unsigned multiply
  localparam logic [2:0] FN_DIVU = 3'd4;  // unsigned divide / remainder

  // Control FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_SIGN = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Request message is {fn, a, b}: 3 + 2W bits, b in the low W bits
  localparam int REQ_FN_W  = 3;
  localparam int REQ_B_LSB = 0;

  function automatic int req_msg_w(input int w);
    return REQ_FN_W + 2 * w;
  endfunction

  function automatic int req_fn_lsb(input int w);
    return 2 * w;
  endfunction

  function automatic int req_a_lsb(input int w);
    return w;
  endfunction

  // Signed functions take operand magnitudes and need a sign fixup at the end
  function automatic logic fn_is_signed(input logic [2:0] fn);
    return (fn == FN_MUL) || (fn == FN_DIV);
  endfunction

  function automatic logic fn_is_mul(input logic [2:0] fn);
    return (fn == FN_MUL) || (fn == FN_MULU);
  endfunction

  function automatic logic fn_is_div(input logic [2:0] fn);
    return (fn == FN_DIV) || (fn == FN_DIVU);
  endfunction

endpackage

// File: rtl/imuldiv_int_muldiv_iterative_param_if.sv
// Request/response bundle between a requester and the mul/div unit.
// No storage; latency is defined by the unit on the slave side.
// Both directions use val/rdy; a beat moves when val && rdy on a rising edge.
interface imuldiv_int_muldiv_iterative_param_if #(
  parameter int W = 32
);

  logic [2:0]     muldivreq_msg_fn;
  logic [W-1:0]   muldivreq_msg_a;
  logic [W-1:0]   muldivreq_msg_b;
  logic           muldivreq_val;
  logic           muldivreq_rdy;
  logic [2*W-1:0] muldivresp_msg_result;
  logic           muldivresp_val;
  logic           muldivresp_rdy;

  // Requester side: issues operations and consumes results
  modport master (
    output muldivreq_msg_fn,
    output muldivreq_msg_a,
    output muldivreq_msg_b,
    output muldivreq_val,
    input  muldivreq_rdy,
    input  muldivresp_msg_result,
    input  muldivresp_val,
    output muldivresp_rdy
  );

  // Unit side: accepts operations and produces results
  modport slave (
    input  muldivreq_msg_fn,
    input  muldivreq_msg_a,
    input  muldivreq_msg_b,
    input  muldivreq_val,
    output muldivreq_rdy,
    output muldivresp_msg_result,
    output muldivresp_val,
    input  muldivresp_rdy
  );

endinterface

// File: rtl/imuldiv_int_muldiv_iterative_param_divstep.sv
// RADIX_BITS chained restoring-division steps on {remainder, dividend, divisor}.
// Purely combinational, zero cycles.
// No handshake; the caller decides when to register the updated pair.
module imuldiv_divstep_unit #(
  parameter int W          = 32,
  parameter int RADIX_BITS = 1
) (
  input  logic [W:0]   rem_in,
  input  logic [W-1:0] dvd_in,
  input  logic [W-1:0] dvs_in,
  output logic [W:0]   rem_out,
  output logic [W-1:0] dvd_out
);

  logic [W:0]   rem_w;
  logic [W:0]   rem_sh;
  logic [W:0]   dvs_ext;
  logic [W-1:0] dvd_w;

  assign dvs_ext = {1'b0, dvs_in};

  // Each step shifts the next dividend MSB into the remainder, trial-subtracts
  // the divisor and shifts the resulting quotient bit into the dividend LSB.
  // The remainder stays below the divisor between steps, so dropping its top
  // bit on the shift loses nothing; the extra bit holds the shifted value.
  always_comb begin
    rem_w  = rem_in;
    dvd_w  = dvd_in;
    rem_sh = '0;
    for (int i = 0; i < RADIX_BITS; i++) begin
      rem_sh = (rem_w << 1) | {{W{1'b0}}, dvd_w[W-1]};
      dvd_w  = dvd_w << 1;
      if (rem_sh >= dvs_ext) begin
        rem_w    = rem_sh - dvs_ext;
        dvd_w[0] = 1'b1;
      end else begin
        rem_w = rem_sh;
      end
    end
  end

  assign rem_out = rem_w;
  assign dvd_out = dvd_w;

endmodule

// File: rtl/imuldiv_int_muldiv_iterative_param.sv
// Iterative signed/unsigned multiply and divide/remainder, RADIX_BITS bits per cycle.
// Response valid W/RADIX_BITS+1 cycles after request acceptance; one op in flight.
// Request rdy only in IDLE; result held in DONE until the response is taken.
module imuldiv_int_muldiv_iterative_param
  import imuldiv_int_muldiv_iterative_param_pkg::*;
#(
  parameter int W          = 32,
  parameter int RADIX_BITS = 1
) (
  input logic clk,
  input logic reset,
  imuldiv_int_muldiv_iterative_param_if.slave io
);

  localparam int ITERS = W / RADIX_BITS;
  localparam int CNT_W = $clog2(ITERS + 1);
  localparam int REQ_W = req_msg_w(W);

  state_t state;
  state_t state_nxt;
  logic   req_rdy;
  logic   resp_val;

  // Request message fields
  logic [REQ_W-1:0] req_msg;
  logic [2:0]       req_fn;
  logic [W-1:0]     req_a;
  logic [W-1:0]     req_b;
  logic             req_signed;
  logic [W-1:0]     a_mag;
  logic [W-1:0]     b_mag;

  // Operation state captured at acceptance
  logic [2:0]       fn_q;
  logic             sign_a;
  logic             sign_b;
  logic [CNT_W-1:0] cnt;

  // Multiply datapath: 2W accumulator, left-shifting multiplicand, right-shifting multiplier
  logic [2*W-1:0] acc;
  logic [2*W-1:0] acc_nxt;
  logic [2*W-1:0] mcand;
  logic [W-1:0]   mplier;

  // Divide datapath: W+1 remainder, dividend register that fills with quotient bits
  logic [W:0]     rem;
  logic [W:0]     rem_step;
  logic [W-1:0]   dvd;
  logic [W-1:0]   dvd_step;
  logic [W-1:0]   dvs;

  // Sign-fixed results and the output register
  logic [W-1:0]   rem_mag;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quo_fix;
  logic [W-1:0]   rem_fix;
  logic [2*W-1:0] result_nxt;
  logic [2*W-1:0] result_q;

  assign req_msg    = {io.muldivreq_msg_fn, io.muldivreq_msg_a, io.muldivreq_msg_b};
  assign req_fn     = req_msg[req_fn_lsb(W) +: REQ_FN_W];
  assign req_a      = req_msg[req_a_lsb(W) +: W];
  assign req_b      = req_msg[REQ_B_LSB +: W];
  assign req_signed = fn_is_signed(req_fn);

  // The most negative value has no positive twin, but its W-bit pattern read
  // as unsigned is exactly its magnitude, so plain negation is sufficient.
  assign a_mag = (req_signed && req_a[W-1]) ? -req_a : req_a;
  assign b_mag = (req_signed && req_b[W-1]) ? -req_b : req_b;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nxt = state;
    req_rdy   = 1'b0;
    resp_val  = 1'b0;
    case (state)
      ST_IDLE: begin
        req_rdy = 1'b1;
        if (io.muldivreq_val) begin
          state_nxt = ST_CALC;
        end
      end
      ST_CALC: begin
        if (cnt == CNT_W'(1)) begin
          state_nxt = ST_SIGN;
        end
      end
      ST_SIGN: begin
        state_nxt = ST_DONE;
      end
      ST_DONE: begin
        resp_val = 1'b1;
        if (io.muldivresp_rdy) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // One radix step of shift-add multiplication over the 2W accumulator
  always_comb begin
    acc_nxt = acc;
    for (int i = 0; i < RADIX_BITS; i++) begin
      if (mplier[i]) begin
        acc_nxt = acc_nxt + (mcand << i);
      end
    end
  end

  imuldiv_divstep_unit #(
    .W          (W),
    .RADIX_BITS (RADIX_BITS)
  ) u_divstep (
    .rem_in  (rem),
    .dvd_in  (dvd),
    .dvs_in  (dvs),
    .rem_out (rem_step),
    .dvd_out (dvd_step)
  );

  // Final remainder is below the divisor (or equals |A| on divide by zero)
  assign rem_mag = W'(rem);

  // Sign fixup and result selection, registered in SIGN. For a zero divisor
  // the quotient is forced to all ones; the remainder path already yields A,
  // because |A| re-negated by sign_a restores the original operand.
  always_comb begin
    prod_fix   = acc;
    quo_fix    = dvd;
    rem_fix    = rem_mag;
    result_nxt = '0;
    if ((fn_q == FN_MUL) && (sign_a ^ sign_b)) begin
      prod_fix = -acc;
    end
    if (fn_q == FN_DIV) begin
      if (sign_a ^ sign_b) begin
        quo_fix = -dvd;
      end
      if (sign_a) begin
        rem_fix = -rem_mag;
      end
    end
    if (dvs == '0) begin
      quo_fix = '1;
    end
    if (fn_is_mul(fn_q)) begin
      result_nxt = prod_fix;
    end else if (fn_is_div(fn_q)) begin
      result_nxt = {rem_fix, quo_fix};
    end
  end

  // Operand capture, iteration and result register
  always_ff @(posedge clk) begin
    if (reset) begin
      fn_q     <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      rem      <= '0;
      dvd      <= '0;
      dvs      <= '0;
      result_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (io.muldivreq_val) begin
            fn_q   <= req_fn;
            sign_a <= req_signed & req_a[W-1];
            sign_b <= req_signed & req_b[W-1];
            cnt    <= CNT_W'(ITERS);
            acc    <= '0;
            mcand  <= {{W{1'b0}}, a_mag};
            mplier <= b_mag;
            rem    <= '0;
            dvd    <= a_mag;
            dvs    <= b_mag;
          end
        end
        ST_CALC: begin
          // Both datapaths advance; the result mux picks the one fn_q needs
          acc    <= acc_nxt;
          mcand  <= mcand << RADIX_BITS;
          mplier <= mplier >> RADIX_BITS;
          rem    <= rem_step;
          dvd    <= dvd_step;
          cnt    <= cnt - CNT_W'(1);
        end
        ST_SIGN: begin
          result_q <= result_nxt;
        end
        default: begin
        end
      endcase
    end
  end

  assign io.muldivreq_rdy         = req_rdy;
  assign io.muldivresp_val        = resp_val;
  assign io.muldivresp_msg_result = result_q;

endmodule

// File: tb/tb_imuldiv_int_muldiv_iterative_param.sv
// Drives a RADIX_BITS=1 and a RADIX_BITS=4 instance in lockstep with the same
// operations and compares both against constants and an arithmetic model.
// Response ready is held low until both units respond, then pulsed.
module tb_imuldiv_int_muldiv_iterative_param;

  localparam int W = 32;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  int n_chk = 0;
  int n_err = 0;

  logic [2:0]  r_fn;
  logic [31:0] r_a;
  logic [31:0] r_b;
  int          sel;

  always #5 clk = ~clk;

  imuldiv_int_muldiv_iterative_param_if #(.W(W)) bus_r1 ();
  imuldiv_int_muldiv_iterative_param_if #(.W(W)) bus_r4 ();

  imuldiv_int_muldiv_iterative_param #(.W(W), .RADIX_BITS(1)) dut_r1 (
    .clk   (clk),
    .reset (reset),
    .io    (bus_r1.slave)
  );

  imuldiv_int_muldiv_iterative_param #(.W(W), .RADIX_BITS(4)) dut_r4 (
    .clk   (clk),
    .reset (reset),
    .io    (bus_r4.slave)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference behaviour from plain integer arithmetic
  function automatic logic [63:0] ref_muldiv(input logic [2:0] fn, input logic [31:0] a,
                                             input logic [31:0] b);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur;
    logic [63:0]     r;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    r  = '0;
    case (fn)
      3'd0: r = sa * sb;
      3'd2: r = ua * ub;
      3'd1: begin
        if (b == 32'd0) begin
          r = {a, 32'hffffffff};
        end else begin
          sq = sa / sb;
          sr = sa % sb;
          r  = {sr[31:0], sq[31:0]};
        end
      end
      3'd4: begin
        if (b == 32'd0) begin
          r = {a, 32'hffffffff};
        end else begin
          uq = ua / ub;
          ur = ua % ub;
          r  = {ur[31:0], uq[31:0]};
        end
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic drive_req(input logic v, input logic [2:0] fn, input logic [31:0] a,
                           input logic [31:0] b);
    bus_r1.muldivreq_val    = v;
    bus_r1.muldivreq_msg_fn = fn;
    bus_r1.muldivreq_msg_a  = a;
    bus_r1.muldivreq_msg_b  = b;
    bus_r4.muldivreq_val    = v;
    bus_r4.muldivreq_msg_fn = fn;
    bus_r4.muldivreq_msg_a  = a;
    bus_r4.muldivreq_msg_b  = b;
  endtask

  task automatic drive_resp_rdy(input logic r);
    bus_r1.muldivresp_rdy = r;
    bus_r4.muldivresp_rdy = r;
  endtask

  // One full operation on both units; hold = extra stalled cycles in DONE
  task automatic do_op(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input int hold);
    int lat1;
    int lat4;
    @(negedge clk);
    check_val("req_rdy_idle_r1", {63'b0, bus_r1.muldivreq_rdy}, 64'd1);
    check_val("req_rdy_idle_r4", {63'b0, bus_r4.muldivreq_rdy}, 64'd1);
    drive_req(1'b1, fn, a, b);
    @(posedge clk);
    #1;
    // Scramble inputs after acceptance; they must not affect the result
    drive_req(1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom);
    lat1 = -1;
    lat4 = -1;
    for (int k = 1; k <= 60 && (lat1 < 0 || lat4 < 0); k++) begin
      @(posedge clk);
      #1;
      if (k == 2) begin
        check_val("req_rdy_busy_r1", {63'b0, bus_r1.muldivreq_rdy}, 64'd0);
        check_val("req_rdy_busy_r4", {63'b0, bus_r4.muldivreq_rdy}, 64'd0);
      end
      if (lat1 < 0 && bus_r1.muldivresp_val) lat1 = k;
      if (lat4 < 0 && bus_r4.muldivresp_val) lat4 = k;
    end
    check_val("latency_r1", 64'(lat1), 64'(W / 1 + 1));
    check_val("latency_r4", 64'(lat4), 64'(W / 4 + 1));
    check_val("result_r1", bus_r1.muldivresp_msg_result, exp);
    check_val("result_r4", bus_r4.muldivresp_msg_result, exp);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check_val("hold_result_r1", bus_r1.muldivresp_msg_result, exp);
      check_val("hold_result_r4", bus_r4.muldivresp_msg_result, exp);
      check_val("hold_val_r4", {63'b0, bus_r4.muldivresp_val}, 64'd1);
      check_val("hold_req_rdy_r4", {63'b0, bus_r4.muldivreq_rdy}, 64'd0);
    end
    @(negedge clk);
    drive_resp_rdy(1'b1);
    @(posedge clk);
    #1;
    drive_resp_rdy(1'b0);
    check_val("resp_val_drop_r1", {63'b0, bus_r1.muldivresp_val}, 64'd0);
    check_val("resp_val_drop_r4", {63'b0, bus_r4.muldivresp_val}, 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_req(1'b0, 3'd0, 32'd0, 32'd0);
    drive_resp_rdy(1'b0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_val("rst_req_rdy_r1", {63'b0, bus_r1.muldivreq_rdy}, 64'd1);
    check_val("rst_req_rdy_r4", {63'b0, bus_r4.muldivreq_rdy}, 64'd1);
    check_val("rst_resp_val_r1", {63'b0, bus_r1.muldivresp_val}, 64'd0);
    check_val("rst_resp_val_r4", {63'b0, bus_r4.muldivresp_val}, 64'd0);
    check_val("rst_result_r1", bus_r1.muldivresp_msg_result, 64'd0);
    check_val("rst_result_r4", bus_r4.muldivresp_msg_result, 64'd0);

    // Directed vectors with hand-derived results
    do_op(3'd0, 32'hfffffff8, 32'h00000008, 64'hffffffff_ffffffc0, 0);
    do_op(3'd2, 32'hffffffff, 32'hffffffff, 64'hfffffffe_00000001, 0);
    do_op(3'd0, 32'hffffffff, 32'hffffffff, 64'h00000000_00000001, 0);
    do_op(3'd1, 32'hf5fe4fbc, 32'hffffb14a, 64'hffffcc8e_0000208b, 5);
    do_op(3'd4, 32'h0000000b, 32'h00000003, 64'h00000002_00000003, 0);
    do_op(3'd4, 32'h00000007, 32'h00000000, 64'h00000007_ffffffff, 0);
    do_op(3'd1, 32'h80000000, 32'hffffffff, 64'h00000000_80000000, 0);
    do_op(3'd1, 32'hfffffff9, 32'h00000000, 64'hfffffff9_ffffffff, 0);
    do_op(3'd1, 32'hfffffff9, 32'h00000002, 64'hffffffff_fffffffd, 2);
    do_op(3'd3, 32'h12345678, 32'h9abcdef0, 64'h0, 0);
    do_op(3'd7, 32'hdeadbeef, 32'h00000005, 64'h0, 0);

    // Randomised operations against the arithmetic model
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1:    r_fn = 3'd0;
        2, 3:    r_fn = 3'd1;
        4, 5:    r_fn = 3'd2;
        6, 7:    r_fn = 3'd4;
        8: begin
          case ($urandom_range(0, 3))
            0:       r_fn = 3'd3;
            1:       r_fn = 3'd5;
            2:       r_fn = 3'd6;
            default: r_fn = 3'd7;
          endcase
        end
        default: r_fn = ($urandom_range(0, 1) != 0) ? 3'd1 : 3'd4;
      endcase
      case ($urandom_range(0, 3))
        0: begin
          r_a = $urandom;
          r_b = $urandom;
        end
        1: begin
          r_a = $urandom_range(0, 255);
          r_b = $urandom_range(1, 255);
          if ($urandom_range(0, 1) != 0) r_a = -r_a;
          if ($urandom_range(0, 1) != 0) r_b = -r_b;
        end
        2: begin
          r_a = 32'h80000000;
          r_b = 32'hffffffff;
        end
        default: begin
          r_a = $urandom;
          r_b = $urandom_range(0, 15);
        end
      endcase
      if (sel == 9) r_b = 32'd0;
      do_op(r_fn, r_a, r_b, ref_muldiv(r_fn, r_a, r_b), $urandom_range(0, 3));
    end

    // Reset mid-operation: r1 is still iterating; after 12 cycles r4 is in DONE
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      drive_req(1'b1, 3'd0, 32'd5, 32'd7);
      @(posedge clk);
      #1;
      drive_req(1'b0, 3'd0, 32'd0, 32'd0);
      repeat ((j == 0) ? 4 : 12) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check_val("midrst_req_rdy_r1", {63'b0, bus_r1.muldivreq_rdy}, 64'd1);
      check_val("midrst_req_rdy_r4", {63'b0, bus_r4.muldivreq_rdy}, 64'd1);
      check_val("midrst_resp_val_r1", {63'b0, bus_r1.muldivresp_val}, 64'd0);
      check_val("midrst_resp_val_r4", {63'b0, bus_r4.muldivresp_val}, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      do_op(3'd0, 32'h00000003, 32'h00000008, 64'h00000000_00000018, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/imuldiv_int_muldiv_iterative_param.md
Name: imuldiv_int_muldiv_iterative_param

Overview:
- Parametrised iterative integer multiply/divide unit for the PARC pipeline's long-latency functional unit.
- Accepts one request at a time over a val/rdy request interface. Returns a 2W-bit result over a val/rdy response interface.
- Generalises the fixed 32-bit, radix-2 unit in two ways:
  - operand width W and bits retired per cycle (RADIX_BITS) are parameters;
  - adds unsigned multiply and defined divide-by-zero and overflow behaviour.

Parameters:
- W, 32: operand width; result width is 2W.
- RADIX_BITS, 1: bits processed per compute cycle. Legal values are 1, 2 and 4; W must be divisible by RADIX_BITS.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- muldivreq_msg_fn  input  3  function select: 0 = mul (signed), 1 = div/rem (signed), 2 = mulu (unsigned), 4 = divu/remu.
- muldivreq_msg_a  input  W  operand A (multiplicand or dividend).
- muldivreq_msg_b  input  W  operand B (multiplier or divisor).
- muldivreq_val  input  1  request valid.
- muldivreq_rdy  output  1  request ready.
- muldivresp_msg_result  output  2W  result. Multiply: full 2W-bit product. Divide: {remainder, quotient}.
- muldivresp_val  output  1  response valid.
- muldivresp_rdy  input  1  response ready.

Behaviour:
- States are IDLE, CALC, SIGN, DONE. After reset: state IDLE, muldivreq_rdy=1, muldivresp_val=0, result register 0.
- IDLE:
  - muldivreq_rdy=1.
  - On val&&rdy: latch fn and take operand magnitudes; for signed fns also record sign_a, sign_b.
  - Load the iteration counter with W/RADIX_BITS and go to CALC.
- CALC:
  - muldivreq_rdy=0, muldivresp_val=0.
  - Each cycle retires RADIX_BITS bits and decrements the counter.
  - When the counter reaches 1, go to SIGN on the next edge.
  - Multiply: shift-add over 2W-bit accumulator.
  - Divide: RADIX_BITS chained restoring-division steps per cycle, remainder W+1 bits wide.
- SIGN (1 cycle):
  - Signed mul: negate the product if sign_a^sign_b.
  - Signed div: negate the quotient if sign_a^sign_b; negate the remainder if sign_a.
  - Write the result register, then go to DONE.
- DONE:
  - muldivresp_val=1 and the result is held stable while val&&!rdy.
  - On muldivresp_rdy, go to IDLE.
  - No request is accepted in the same cycle.
- Latency: muldivresp_val rises W/RADIX_BITS+1 cycles after the request-acceptance edge. Minimum spacing between accepted requests is W/RADIX_BITS+3 cycles.
- Divide by zero (fn 1 or 4): quotient = all ones, remainder = A unchanged, no sign fixup; normal latency.
- Signed overflow (A = 2^(W-1), B = -1): quotient = 2^(W-1), remainder = 0.
- Unsupported fn (3, 5, 6, 7): result = 0 with normal latency; the handshake still completes.
- Reset asserted in any state:
  - next state IDLE, in-flight operation discarded;
  - muldivresp_val=0 on the following cycle;
  - a response pending in DONE is dropped.
- Inputs are sampled only at the acceptance edge. Changes to A, B or fn during CALC have no effect.

Decomposition:
- Shared package/header (imuldiv-MulDivReqMsg extension):
  - fn encodings (FN_MUL=0, FN_DIV=1, FN_MULU=2, FN_DIVU=4) and the state encodings;
  - req message width 3+2W with pack/unpack helpers.
- One sub-module: imuldiv_divstep_unit, combinational, RADIX_BITS chained restoring steps. It takes {remainder, dividend shift register, divisor} and returns the updated pair.
- Control FSM and counter live in the top module.

Test Plan:
- W=32, RADIX_BITS=1, mul with A=fffffff8, B=00000008 → result ffffffff_ffffffc0; muldivresp_val exactly 33 cycles after acceptance.
- mulu with A=ffffffff, B=ffffffff → result fffffffe_00000001. The same operands with fn 0 → 00000000_00000001.
- div with A=f5fe4fbc, B=ffffb14a → result ffffcc8e_0000208b. divu with A=0000000b, B=00000003 → result 00000002_00000003.
- divu with A=00000007, B=0 → result 00000007_ffffffff. div with A=80000000, B=ffffffff → result 00000000_80000000.
- Rebuild with RADIX_BITS=4: run the same vector set with results identical. muldivresp_val arrives 9 cycles after acceptance. Also hold muldivresp_rdy=0 for 5 cycles and check that the result stays stable and muldivreq_rdy stays 0.
- Assert reset for 1 cycle mid-CALC → muldivreq_rdy=1 and muldivresp_val=0 next cycle. A following mul with A=00000003, B=00000008 returns 00000000_00000018.
